// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings and read-arbiter state type.
// No logic, so no latency or backpressure of its own.
package axi4_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam logic [2:0] AXI_SIZE_1B   = 3'b000;
    localparam logic [2:0] AXI_SIZE_2B   = 3'b001;
    localparam logic [2:0] AXI_SIZE_4B   = 3'b010;
    localparam logic [2:0] AXI_SIZE_8B   = 3'b011;
    localparam logic [2:0] AXI_SIZE_16B  = 3'b100;
    localparam logic [2:0] AXI_SIZE_32B  = 3'b101;
    localparam logic [2:0] AXI_SIZE_64B  = 3'b110;
    localparam logic [2:0] AXI_SIZE_128B = 3'b111;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAddress = 2'd1,
        StData    = 2'd2
    } state_e;

endpackage

// File: rtl/axi4_read_arbiter_if.sv
// Requester-side and shared master-side AR/R signals of the read arbiter.
// master = arbiter view, slave = view of the surrounding requesters and memory.
interface axi4_read_arbiter_if #(
    parameter int NUM_REQ      = 4,
    parameter int ADDRESS_SIZE = 32,
    parameter int DATA_SIZE    = 32
);
    logic [NUM_REQ*ADDRESS_SIZE-1:0] s_axi_araddr;
    logic [NUM_REQ*8-1:0]            s_axi_arlen;
    logic [NUM_REQ*3-1:0]            s_axi_arsize;
    logic [NUM_REQ*2-1:0]            s_axi_arburst;
    logic [NUM_REQ-1:0]              s_axi_arvalid;
    logic [NUM_REQ-1:0]              s_axi_arready;
    logic [DATA_SIZE-1:0]            s_axi_rdata;
    logic [1:0]                      s_axi_rresp;
    logic                            s_axi_rlast;
    logic [NUM_REQ-1:0]              s_axi_rvalid;
    logic [NUM_REQ-1:0]              s_axi_rready;

    logic [ADDRESS_SIZE-1:0]         m_axi_araddr;
    logic [7:0]                      m_axi_arlen;
    logic [2:0]                      m_axi_arsize;
    logic [1:0]                      m_axi_arburst;
    logic                            m_axi_arvalid;
    logic                            m_axi_arready;
    logic [DATA_SIZE-1:0]            m_axi_rdata;
    logic [1:0]                      m_axi_rresp;
    logic                            m_axi_rlast;
    logic                            m_axi_rvalid;
    logic                            m_axi_rready;

    modport master (
        input  s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid, s_axi_rready,
        output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid, m_axi_rready,
        input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
    );

    modport slave (
        output s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid, s_axi_rready,
        input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid, m_axi_rready,
        output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester above ptr, wrapping; purely combinational.
// Zero latency; no backpressure, gnt_vld low when nothing is requesting.
module rr_arbiter #(
    parameter int  NUM_REQ = 4,
    localparam int GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [GRANT_W-1:0] gnt_idx,
    output logic               gnt_vld
);

    always_comb begin
        logic [GRANT_W-1:0] idx;
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        // i == NUM_REQ lands back on ptr itself, so it has lowest priority
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = GRANT_W'((int'(ptr) + i) % NUM_REQ);
            if (!gnt_vld && req[idx]) begin
                gnt_vld  = 1'b1;
                gnt_idx  = idx;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi4_read_arbiter.sv
// Round-robin AXI4 read arbiter, one burst in flight; AR out 1 cycle after accept, R routed combinationally.
// Backpressure: requester rready drives m_axi_rready; AR held until m_axi_arready. Option: AXI4_READ_ARB_BEAT_CHECK_EN.
module axi4_read_arbiter
    import axi4_pkg::*;
#(
    parameter int  NUM_REQ      = 4,
    parameter int  ADDRESS_SIZE = 32,
    parameter int  DATA_SIZE    = 32,
    localparam int GRANT_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               aclk,
    input  logic               aresetn,
    axi4_read_arbiter_if.master bus,
    output logic               busy,
    output logic [GRANT_W-1:0] grant_id,
    output logic               err_beat
);

    state_e             st, st_nxt;
    logic [GRANT_W-1:0] rr_ptr;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [GRANT_W-1:0] arb_idx;
    logic               arb_vld;
    logic               ar_acc, r_hs, r_done;

    logic [ADDRESS_SIZE-1:0] req_addr  [NUM_REQ];
    logic [7:0]              req_len   [NUM_REQ];
    logic [2:0]              req_size  [NUM_REQ];
    logic [1:0]              req_burst [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_addr[i]  = bus.s_axi_araddr[i*ADDRESS_SIZE +: ADDRESS_SIZE];
        assign req_len[i]   = bus.s_axi_arlen[i*8 +: 8];
        assign req_size[i]  = bus.s_axi_arsize[i*3 +: 3];
        assign req_burst[i] = bus.s_axi_arburst[i*2 +: 2];
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (bus.s_axi_arvalid),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    assign ar_acc = (st == StIdle) && arb_vld;
    assign r_hs   = (st == StData) && bus.m_axi_rvalid && bus.m_axi_rready;
    assign r_done = r_hs && bus.m_axi_rlast;
    assign busy   = (st != StIdle);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) st <= StIdle;
        else          st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        unique case (st)
            StIdle:    if (arb_vld)           st_nxt = StAddress;
            StAddress: if (bus.m_axi_arready) st_nxt = StData;
            StData:    if (r_done)            st_nxt = StIdle;
            default:                          st_nxt = StIdle;
        endcase
    end

    always_comb begin
        bus.s_axi_arready = (st == StIdle) ? arb_gnt : '0;
        bus.s_axi_rvalid  = '0;
        bus.m_axi_rready  = 1'b0;
        if (st == StData) begin
            bus.s_axi_rvalid[grant_id] = bus.m_axi_rvalid;
            bus.m_axi_rready           = bus.s_axi_rready[grant_id];
        end
    end

    // Data/resp/last are broadcast; only the one-hot rvalid says who owns the beat
    assign bus.s_axi_rdata = bus.m_axi_rdata;
    assign bus.s_axi_rresp = bus.m_axi_rresp;
    assign bus.s_axi_rlast = bus.m_axi_rlast;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rr_ptr            <= '0;
            grant_id          <= '0;
            bus.m_axi_araddr  <= '0;
            bus.m_axi_arlen   <= '0;
            bus.m_axi_arsize  <= '0;
            bus.m_axi_arburst <= '0;
            bus.m_axi_arvalid <= 1'b0;
        end else begin
            if (ar_acc) begin
                grant_id          <= arb_idx;
                bus.m_axi_araddr  <= req_addr[arb_idx];
                bus.m_axi_arlen   <= req_len[arb_idx];
                bus.m_axi_arsize  <= req_size[arb_idx];
                bus.m_axi_arburst <= req_burst[arb_idx];
                bus.m_axi_arvalid <= 1'b1;
            end else if ((st == StAddress) && bus.m_axi_arready) begin
                bus.m_axi_arvalid <= 1'b0;
            end
            if (r_done) rr_ptr <= grant_id;
        end
    end

`ifdef AXI4_READ_ARB_BEAT_CHECK_EN
    logic [7:0] beat_cnt;

    // rlast must coincide exactly with the beat whose index equals arlen
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_cnt <= '0;
            err_beat <= 1'b0;
        end else if (ar_acc) begin
            beat_cnt <= '0;
        end else if (r_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (bus.m_axi_rlast != (beat_cnt == bus.m_axi_arlen)) err_beat <= 1'b1;
        end
    end
`else
    assign err_beat = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_read_arbiter.sv
// Directed bench for axi4_read_arbiter with NUM_REQ=4, 32-bit address and data.
module tb_axi4_read_arbiter;
    import axi4_pkg::*;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef AXI4_READ_ARB_BEAT_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic       aclk = 1'b0;
    logic       aresetn;
    logic       busy;
    logic [1:0] grant_id;
    logic       err_beat;
    int         n_chk  = 0;
    int         n_fail = 0;
    logic [31:0] exp_addr [NR];
    logic [7:0]  exp_len  [NR];
    int          rr_seq   [6] = '{0, 1, 2, 3, 0, 1};

    axi4_read_arbiter_if #(.NUM_REQ(NR), .ADDRESS_SIZE(AW), .DATA_SIZE(DW)) bus ();

    axi4_read_arbiter #(.NUM_REQ(NR), .ADDRESS_SIZE(AW), .DATA_SIZE(DW)) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .bus      (bus),
        .busy     (busy),
        .grant_id (grant_id),
        .err_beat (err_beat)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge aclk);
        #1;
    endtask

    task automatic mid();
        @(negedge aclk);
    endtask

    task automatic set_req(input int r, input logic [31:0] addr, input logic [7:0] len);
        bus.s_axi_araddr[r*AW +: AW] = addr;
        bus.s_axi_arlen[r*8 +: 8]    = len;
        bus.s_axi_arsize[r*3 +: 3]   = AXI_SIZE_4B;
        bus.s_axi_arburst[r*2 +: 2]  = AXI_BURST_INCR;
        exp_addr[r] = addr;
        exp_len[r]  = len;
    endtask

    // Entered one tick after a rising edge with the arbiter idle and arvalid already driven.
    task automatic run_txn(input int g, input int nbeats, input int ar_wait, input bit drop,
                           input int stall_beat, input int stall_n, input int rst_beat);
        logic [31:0] d;
        mid();
        check("idle_busy", busy, 0);
        check("arready_onehot", bus.s_axi_arready, 64'd1 << g);
        nxt();
        if (drop) bus.s_axi_arvalid[g] = 1'b0;
        for (int k = 0; k <= ar_wait; k++) begin
            bus.m_axi_arready = (k == ar_wait);
            mid();
            check("m_arvalid", bus.m_axi_arvalid, 1);
            check("m_araddr", bus.m_axi_araddr, exp_addr[g]);
            check("m_arlen", bus.m_axi_arlen, exp_len[g]);
            check("m_arburst", bus.m_axi_arburst, AXI_BURST_INCR);
            check("grant_id", grant_id, g);
            check("busy_addr", busy, 1);
            check("arready_in_addr", bus.s_axi_arready, 0);
            nxt();
        end
        bus.m_axi_arready = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            d = 32'hD000_0000 + 32'(g * 256 + b);
            bus.m_axi_rvalid = 1'b1;
            bus.m_axi_rdata  = d;
            bus.m_axi_rresp  = (b == 1) ? SLVERR : OKAY;
            bus.m_axi_rlast  = (b == nbeats - 1);
            if (b == stall_beat) begin
                for (int s = 0; s < stall_n; s++) begin
                    bus.s_axi_rready[g] = 1'b0;
                    mid();
                    check("stall_m_rready", bus.m_axi_rready, 0);
                    check("stall_s_rvalid", bus.s_axi_rvalid, 64'd1 << g);
                    nxt();
                end
            end
            bus.s_axi_rready[g] = 1'b1;
            mid();
            check("s_rvalid", bus.s_axi_rvalid, 64'd1 << g);
            check("m_rready", bus.m_axi_rready, 1);
            check("m_arvalid_data", bus.m_axi_arvalid, 0);
            check("s_rdata", bus.s_axi_rdata, d);
            check("s_rresp", bus.s_axi_rresp, (b == 1) ? SLVERR : OKAY);
            check("s_rlast", bus.s_axi_rlast, (b == nbeats - 1));
            if (b == rst_beat) begin
                #1 aresetn = 1'b0;
                #1;
                check("rst_busy", busy, 0);
                check("rst_grant", grant_id, 0);
                check("rst_m_arvalid", bus.m_axi_arvalid, 0);
                check("rst_m_araddr", bus.m_axi_araddr, 0);
                check("rst_m_arlen", bus.m_axi_arlen, 0);
                check("rst_m_rready", bus.m_axi_rready, 0);
                check("rst_s_rvalid", bus.s_axi_rvalid, 0);
                check("rst_err", err_beat, 0);
                bus.m_axi_rvalid = 1'b0;
                bus.m_axi_rlast  = 1'b0;
                nxt();
                aresetn = 1'b1;
                return;
            end
            nxt();
        end
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rlast  = 1'b0;
    endtask

    initial begin
        aresetn           = 1'b0;
        bus.s_axi_araddr  = '0;
        bus.s_axi_arlen   = '0;
        bus.s_axi_arsize  = '0;
        bus.s_axi_arburst = '0;
        bus.s_axi_arvalid = '0;
        bus.s_axi_rready  = '1;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rdata   = '0;
        bus.m_axi_rresp   = OKAY;
        bus.m_axi_rlast   = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, 32'h100 + 32'(i) * 32'h40, 8'd0);

        nxt();
        nxt();
        mid();
        check("reset_busy", busy, 0);
        check("reset_grant", grant_id, 0);
        check("reset_m_arvalid", bus.m_axi_arvalid, 0);
        check("reset_m_araddr", bus.m_axi_araddr, 0);
        check("reset_err", err_beat, 0);
        check("reset_arready", bus.s_axi_arready, 0);
        nxt();
        aresetn = 1'b1;

        // A master beat while idle must not be accepted or forwarded
        bus.m_axi_rvalid = 1'b1;
        mid();
        check("stray_m_rready", bus.m_axi_rready, 0);
        check("stray_s_rvalid", bus.s_axi_rvalid, 0);
        nxt();
        bus.m_axi_rvalid = 1'b0;

        // Req0 alone, 4-beat burst, memory stalls AR for 2 cycles
        set_req(0, 32'h100, 8'd3);
        bus.s_axi_arvalid[0] = 1'b1;
        run_txn(0, 4, 2, 1'b1, -1, 0, -1);

        // Move pointer to 1, then req1+req3 contend: 3 wins, then 1
        set_req(0, 32'h100, 8'd0);
        bus.s_axi_arvalid[1] = 1'b1;
        run_txn(1, 1, 0, 1'b1, -1, 0, -1);
        bus.s_axi_arvalid[1] = 1'b1;
        bus.s_axi_arvalid[3] = 1'b1;
        run_txn(3, 1, 0, 1'b1, -1, 0, -1);
        run_txn(1, 1, 0, 1'b1, -1, 0, -1);

        // Pointer to 3, then everyone requesting continuously
        bus.s_axi_arvalid[3] = 1'b1;
        run_txn(3, 1, 0, 1'b1, -1, 0, -1);
        bus.s_axi_arvalid = '1;
        for (int t = 0; t < 6; t++) run_txn(rr_seq[t], 1, 0, 1'b0, -1, 0, -1);
        bus.s_axi_arvalid = '0;

        // Requester stalls rready for 5 cycles before beat 1
        set_req(2, 32'h180, 8'd3);
        bus.s_axi_arvalid[2] = 1'b1;
        run_txn(2, 4, 1, 1'b1, 1, 5, -1);

        // Reset while beat 2 of 8 is on the bus
        set_req(0, 32'h100, 8'd7);
        bus.s_axi_arvalid[0] = 1'b1;
        run_txn(0, 8, 0, 1'b1, -1, 0, 2);

        // Pointer must be back at 0: req2 beats req0
        set_req(0, 32'h100, 8'd0);
        set_req(2, 32'h180, 8'd0);
        bus.s_axi_arvalid[0] = 1'b1;
        bus.s_axi_arvalid[2] = 1'b1;
        run_txn(2, 1, 0, 1'b1, -1, 0, -1);
        run_txn(0, 1, 0, 1'b1, -1, 0, -1);

        // arlen=3 but rlast comes on the third beat
        set_req(1, 32'h140, 8'd3);
        bus.s_axi_arvalid[1] = 1'b1;
        run_txn(1, 3, 0, 1'b1, -1, 0, -1);
        mid();
        check("err_beat_early_rlast", err_beat, EXP_ERR);
        nxt();
        set_req(3, 32'h1C0, 8'd1);
        bus.s_axi_arvalid[3] = 1'b1;
        run_txn(3, 2, 0, 1'b1, -1, 0, -1);
        mid();
        check("err_beat_sticky", err_beat, EXP_ERR);
        check("final_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
